uart_tx_core: RTL and testbench
===============================

# uart_tx_core

- UART transmitter stage directly downstream of the system controller.
- Accepts one parallel byte per `DATA_VALID` handshake, frames it and shifts it out serially on `TX_OUT`: start bit, data LSB first, optional parity bit, stop bit.
- Reports `BUSY` back to the controller.
- `CLK` is the UART TX bit clock: one serial bit per `CLK` cycle. Clock division is done outside this block.

## Interface

Parameters:

- `WIDTH`, default 8: data bits per frame.

Ports:

- `CLK` input, 1: TX bit clock; all logic on the rising edge.
- `RST` input, 1: synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `P_DATA` input, `WIDTH`: parallel byte to transmit.
- `DATA_VALID` input, 1: request to transmit `P_DATA`; accepted only when idle.
- `PAR_EN` input, 1: 1 = insert a parity bit.
- `PAR_TYP` input, 1: 0 = even parity, 1 = odd parity.
- `TX_OUT` output, 1: serial line, registered, idles high.
- `BUSY` output, 1: registered; high from the start bit through the stop bit.

## Operation

- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `TX_OUT`=1, `BUSY`=0.
  - If `DATA_VALID`=1, latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers, then go to START.
- **START:** `TX_OUT`=0, `BUSY`=1. Next state is DATA with the bit counter at 0.
- **DATA:**
  - `TX_OUT` = `latched_data[cnt]`, LSB first.
  - The counter is `$clog2(WIDTH)` bits wide and increments each cycle.
  - When `cnt`=`WIDTH`-1, go to PARITY if the latched `PAR_EN`=1, else to STOP. Reset the counter to 0.
- **PARITY:** `TX_OUT` = XOR-reduce(`latched_data`) XOR `latched_PAR_TYP`. Next state is STOP.
- **STOP:** `TX_OUT`=1, `BUSY`=1. Next state is always IDLE.
- **Latched values:**
  - Parity is computed from the latched data only.
  - Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` after acceptance do not affect the current frame.
- **`DATA_VALID` outside IDLE** is ignored: no queuing and no effect on the frame in progress.
- **Back-to-back frames:**
  - After STOP the block always spends at least one IDLE cycle with `TX_OUT`=1 and `BUSY`=0.
  - A `DATA_VALID` held high through that cycle starts the next frame.
- **Reset:** on any rising edge with `RST`=0, regardless of state:
  - State goes to IDLE; counter and latched data are cleared.
  - `TX_OUT`=1, `BUSY`=0.
  - `DATA_VALID` sampled in the same cycle is ignored.
- **Reset mid-frame:** the frame is abandoned and is not resumed after reset releases.

## Timing

- **Reset values:** `TX_OUT`=1, `BUSY`=0.
- **Acceptance:** `DATA_VALID`=1 sampled in IDLE at edge N.
  - From N+1: `TX_OUT`=0 (start bit), `BUSY`=1.
  - Edges N+2 … N+`WIDTH`+1: data bits 0 … `WIDTH`-1.
  - Then the parity bit (if enabled), then the stop bit.
- **Frame length in `BUSY`-high cycles:** `WIDTH`+2 without parity, `WIDTH`+3 with parity (10 and 11 for `WIDTH`=8).
- **Minimum accept-to-accept period:** `WIDTH`+3 cycles without parity, `WIDTH`+4 with parity (one mandatory IDLE cycle).
- **`BUSY` deassertion:** `BUSY` falls on the edge that leaves STOP. On that same edge `TX_OUT` stays 1 (it continues as the idle level).
- **Glitch-free output:** `TX_OUT` and `BUSY` are flop outputs with no combinational path from any input.

## Test plan

1. **No parity.** Reset, then `P_DATA`=0xA5, `PAR_EN`=0, one-cycle `DATA_VALID`.
   - `TX_OUT` sequence from N+1: 0,1,0,1,0,0,1,0,1,1.
   - `BUSY` high for exactly 10 cycles, then `TX_OUT`=1 and `BUSY`=0.
2. **Parity, 0xA5 (four ones).** `P_DATA`=0xA5, `PAR_EN`=1.
   - `PAR_TYP`=0: parity bit 0.
   - `PAR_TYP`=1: parity bit 1.
   - Frame is 11 `BUSY` cycles, stop bit 1.
3. **Odd-weight data, 0x07.** `PAR_EN`=1, `PAR_TYP`=0: parity bit 1; `PAR_TYP`=1: parity bit 0.
   - Also change `P_DATA` to 0xFF during the frame: transmitted bits are unchanged.
4. **Request while busy.** Pulse `DATA_VALID` with 0x3C while `BUSY`=1 on frame 0xA5.
   - Only 0xA5 is transmitted; the line stays idle afterwards.
5. **Back-to-back.** Hold `DATA_VALID`=1 with 0x55, then 0xAA.
   - Exactly one IDLE cycle between the stop bit and the next start bit.
   - Accept-to-accept period is 11 cycles (`PAR_EN`=0).
6. **Reset mid-frame.** Assert `RST`=0 during data bit 3 of 0xA5.
   - Next edge: `TX_OUT`=1, `BUSY`=0.
   - After release with `DATA_VALID`=0, the line stays idle.
   - A new `DATA_VALID` produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Parallel handshake and serial-line bundle between the system controller and uart_tx_core.
// The controller drives the byte and framing options; the transmitter returns the line and BUSY.
interface uart_tx_core_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             TX_OUT;
    logic             BUSY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  BUSY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: one bit per CLK, frames a latched word as start, data LSB first, optional parity, stop.
// TX_OUT and BUSY are flops loaded from the next-state decode, so they line up with the FSM state.
module uart_tx_core #(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_core_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;
    logic             par_en_r;
    logic             par_en_s;
    logic             par_typ_r;
    logic             par_typ_s;
    logic             tx_r;
    logic             tx_s;
    logic             busy_r;
    logic             busy_s;

    // Even parity is the XOR of the word; odd parity inverts it.
    function automatic logic parity_bit(input logic [WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign bus.TX_OUT = tx_r;
    assign bus.BUSY   = busy_r;

    // Next-state, counter and operand-latch logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        data_s    = data_r;
        par_en_s  = par_en_r;
        par_typ_s = par_typ_r;
        case (state_r)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    data_s    = bus.P_DATA;
                    par_en_s  = bus.PAR_EN;
                    par_typ_s = bus.PAR_TYP;
                    state_s   = START;
                end else begin
                    state_s   = IDLE;
                end
            end
            START: begin
                cnt_s   = CNT_ZERO;
                state_s = DATA;
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = par_en_r ? PARITY : STOP;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = DATA;
                end
            end
            PARITY:  state_s = STOP;
            STOP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode of the state being entered, so the registered line matches the state.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        case (state_s)
            IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
            START: begin
                tx_s   = 1'b0;
                busy_s = 1'b1;
            end
            DATA: begin
                tx_s   = data_s[cnt_s];
                busy_s = 1'b1;
            end
            PARITY: begin
                tx_s   = parity_bit(data_s, par_typ_s);
                busy_s = 1'b1;
            end
            STOP: begin
                tx_s   = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
        endcase
    end

    // State, latches and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            data_r    <= {WIDTH{1'b0}};
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            data_r    <= data_s;
            par_en_r  <= par_en_s;
            par_typ_r <= par_typ_s;
            tx_r      <= tx_s;
            busy_r    <= busy_s;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: captures serial frames bit by bit and compares them
// with hand-built expected frames (index 0 = start bit).
module tb_uart_tx_core;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    uart_tx_core_if #(.WIDTH(8)) bus ();

    uart_tx_core #(.WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present a request for one cycle; on return we sit at the first frame cycle (start bit).
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
    endtask

    // Record n cycles of line and BUSY; optionally pulse a 0x3C request at cycle pulse_at.
    task automatic capture(input int n, input logic dv_during, input int pulse_at,
                           output logic [15:0] txs, output logic [15:0] bsy);
        txs = 16'h0000;
        bsy = 16'h0000;
        for (int i = 0; i < n; i++) begin
            txs[i] = bus.TX_OUT;
            bsy[i] = bus.BUSY;
            if (i == pulse_at) begin
                bus.DATA_VALID = 1'b1;
                bus.P_DATA     = 8'h3C;
            end else begin
                bus.DATA_VALID = dv_during;
            end
            step();
        end
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST            = 1'b0;
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        step();
        step();
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_state tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        RST            = 1'b1;
        bus.DATA_VALID = 1'b0;
        step();
        step();
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_dv_ignored tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
    endtask

    task automatic test_no_parity();
        logic [15:0] txs, bsy;
        send(8'hA5, 1'b0, 1'b0);
        capture(10, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[9:0] !== 10'b1101001010) begin
            failures++;
            $display("FAIL nopar_bits got=%b want=1101001010", txs[9:0]);
        end
        checks++;
        if (bsy[9:0] !== 10'h3FF || bus.BUSY !== 1'b0 || bus.TX_OUT !== 1'b1) begin
            failures++;
            $display("FAIL nopar_busy got=%b end_busy=%b end_tx=%b want 1111111111/0/1",
                     bsy[9:0], bus.BUSY, bus.TX_OUT);
        end
    endtask

    task automatic test_parity_a5();
        logic [15:0] txs, bsy;
        send(8'hA5, 1'b1, 1'b0);
        capture(11, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[10:0] !== {1'b1, 1'b0, 8'hA5, 1'b0} || bsy[10:0] !== 11'h7FF || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL par_a5_even got=%b busy=%b want=%b", txs[10:0], bsy[10:0], {1'b1, 1'b0, 8'hA5, 1'b0});
        end
        step();
        send(8'hA5, 1'b1, 1'b1);
        capture(11, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[10:0] !== {1'b1, 1'b1, 8'hA5, 1'b0} || bsy[10:0] !== 11'h7FF || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL par_a5_odd got=%b busy=%b want=%b", txs[10:0], bsy[10:0], {1'b1, 1'b1, 8'hA5, 1'b0});
        end
    endtask

    task automatic test_parity_07_latch();
        logic [15:0] txs, bsy;
        step();
        send(8'h07, 1'b1, 1'b0);
        bus.P_DATA  = 8'hFF;
        bus.PAR_TYP = 1'b1;
        bus.PAR_EN  = 1'b0;
        capture(11, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0} || bsy[10:0] !== 11'h7FF) begin
            failures++;
            $display("FAIL par_07_even got=%b busy=%b want=%b", txs[10:0], bsy[10:0], {1'b1, 1'b1, 8'h07, 1'b0});
        end
        step();
        send(8'h07, 1'b1, 1'b1);
        bus.P_DATA  = 8'hFF;
        bus.PAR_TYP = 1'b0;
        capture(11, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0} || bsy[10:0] !== 11'h7FF) begin
            failures++;
            $display("FAIL par_07_odd got=%b busy=%b want=%b", txs[10:0], bsy[10:0], {1'b1, 1'b0, 8'h07, 1'b0});
        end
    endtask

    task automatic test_busy_request();
        logic [15:0] txs, bsy;
        int          bad;
        step();
        send(8'hA5, 1'b0, 1'b0);
        capture(10, 1'b0, 3, txs, bsy);
        checks++;
        if (txs[9:0] !== 10'b1101001010 || bsy[9:0] !== 10'h3FF) begin
            failures++;
            $display("FAIL busy_req_frame got=%b busy=%b want=1101001010", txs[9:0], bsy[9:0]);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_req_idle non_idle_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] txs, bsy;
        send(8'h55, 1'b0, 1'b0);
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'hAA;
        capture(10, 1'b1, -1, txs, bsy);
        checks++;
        if (txs[9:0] !== {1'b1, 8'h55, 1'b0} || bsy[9:0] !== 10'h3FF) begin
            failures++;
            $display("FAIL b2b_first got=%b busy=%b want=%b", txs[9:0], bsy[9:0], {1'b1, 8'h55, 1'b0});
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
        capture(10, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[9:0] !== {1'b1, 8'hAA, 1'b0} || bsy[9:0] !== 10'h3FF || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=%b busy=%b want=%b", txs[9:0], bsy[9:0], {1'b1, 8'hAA, 1'b0});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] txs, bsy;
        int          bad;
        step();
        send(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        checks++;
        if (bus.TX_OUT !== 1'b0 || bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL midrst_bit3 tx=%b busy=%b want tx=0 busy=1", bus.TX_OUT, bus.BUSY);
        end
        RST = 1'b0;
        step();
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL midrst_next tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrst_idle non_idle_cycles=%0d want=0", bad);
        end
        send(8'hA5, 1'b0, 1'b0);
        capture(10, 1'b0, -1, txs, bsy);
        checks++;
        if (txs[9:0] !== 10'b1101001010 || bsy[9:0] !== 10'h3FF || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL midrst_refire got=%b busy=%b want=1101001010", txs[9:0], bsy[9:0]);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        RST            = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        @(negedge CLK);
        test_reset();
        test_no_parity();
        test_parity_a5();
        test_parity_07_latch();
        test_busy_request();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
